// File: rtl/change_dispenser.sv
// Coin-return controller: pays out a change amount largest-coin-first through a
// req/ack handshake with the ejector, tracking per-denomination inventory.
module change_dispenser #(
  parameter int unsigned CNT_W   = 6,
  parameter int unsigned INIT_10 = 20,
  parameter int unsigned INIT_5  = 20,
  parameter int unsigned INIT_2  = 20,
  parameter int unsigned INIT_1  = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] change_in,
  input  logic       refill,
  input  logic       eject_ack,
  output logic       eject_req,
  output logic [1:0] coin_sel,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] shortfall,
  output logic [7:0] coins_dispensed,
  output logic [3:0] inv_empty
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_EJECT,
    S_RELEASE,
    S_FINISH
  } state_t;

  // Index k matches the coin_sel encoding: 0 = 1, 1 = 2, 2 = 5, 3 = 10.
  localparam logic [3:0][CNT_W-1:0] INIT_V = {CNT_W'(INIT_10), CNT_W'(INIT_5),
                                              CNT_W'(INIT_2),  CNT_W'(INIT_1)};

  state_t                  state_q, state_d;
  logic [7:0]              rem_q, rem_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [7:0]              sf_q, sf_d;
  logic [1:0]              sel_q, sel_d;
  logic [3:0][CNT_W-1:0]   inv_q, inv_d;
  logic [2:0]              pk;

  function automatic logic [7:0] denom(input logic [1:0] s);
    case (s)
      2'd0:    denom = 8'd1;
      2'd1:    denom = 8'd2;
      2'd2:    denom = 8'd5;
      default: denom = 8'd10;
    endcase
  endfunction

  // Returns {found, sel}: the largest coin that fits the amount and is in stock.
  function automatic logic [2:0] pick(input logic [7:0] amt,
                                      input logic [3:0][CNT_W-1:0] inv);
    pick = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (amt >= denom(2'(i)) && inv[i] != '0) pick = {1'b1, 2'(i)};
    end
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      cnt_q   <= '0;
      sf_q    <= '0;
      sel_q   <= '0;
      inv_q   <= INIT_V;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      sf_q    <= sf_d;
      sel_q   <= sel_d;
      inv_q   <= inv_d;
    end
  end

  // coin_sel is chosen on entry to SELECT so it is already settled the cycle
  // before eject_req rises; SELECT itself only decides EJECT versus FINISH.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    sf_d    = sf_q;
    sel_d   = sel_q;
    inv_d   = inv_q;
    pk      = '0;
    case (state_q)
      S_IDLE: begin
        if (refill) inv_d = INIT_V;
        if (load) begin
          rem_d   = change_in;
          cnt_d   = '0;
          sf_d    = '0;
          state_d = S_SELECT;
          pk      = pick(change_in, inv_d);
          if (pk[2]) sel_d = pk[1:0];
        end
      end
      S_SELECT: begin
        pk = pick(rem_q, inv_q);
        if (pk[2]) begin
          state_d = S_EJECT;
        end else begin
          sf_d    = rem_q;
          state_d = S_FINISH;
        end
      end
      S_EJECT: begin
        if (eject_ack) begin
          rem_d        = rem_q - denom(sel_q);
          inv_d[sel_q] = inv_q[sel_q] - CNT_W'(1);
          cnt_d        = cnt_q + 8'd1;
          state_d      = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!eject_ack) begin
          state_d = S_SELECT;
          pk      = pick(rem_q, inv_q);
          if (pk[2]) sel_d = pk[1:0];
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign eject_req       = (state_q == S_EJECT);
  assign busy            = (state_q != S_IDLE);
  assign done            = (state_q == S_FINISH);
  assign error           = done && (sf_q != '0);
  assign coin_sel        = sel_q;
  assign shortfall       = sf_q;
  assign coins_dispensed = cnt_q;

  always_comb begin
    inv_empty = '0;
    for (int unsigned k = 0; k < 4; k++) inv_empty[k] = (inv_q[k] == '0);
  end

endmodule
